// File: rtl/midi_voice_allocator_pkg.sv
// Shared MIDI decode constants and allocator state encoding.
// Combinational definitions only: no latency, no backpressure.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF      = 4'h8;
  localparam logic [3:0] NOTE_ON       = 4'h9;
  localparam logic [3:0] CC            = 4'hB;
  localparam logic [6:0] ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ASSIGN,
    ST_RETRIG
  } alloc_state_t;

endpackage

// File: rtl/midi_voice_allocator_if.sv
// Decoded MIDI event bus from the framer: valid/ready, one event per accept.
// Source holds command and params stable while valid is high and ready is low.
interface midi_voice_allocator_if;

  logic       event_valid;
  logic       event_ready;
  logic [7:0] midi_command;
  logic [6:0] midi_param1;
  logic [6:0] midi_param2;

  modport master (
    output event_valid,
    output midi_command,
    output midi_param1,
    output midi_param2,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  midi_command,
    input  midi_param1,
    input  midi_param2,
    output event_ready
  );

endinterface

// File: rtl/midi_voice_allocator_voice_pick.sv
// Chooses the target voice for a note-on: retrigger, idle, oldest releasing, oldest overall.
// Purely combinational; steal is set for every choice except a free idle voice.
module voice_pick
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 6,
  parameter int RANK_BITS  = $clog2(NUM_VOICES)
) (
  input  logic [6:0]                      note,
  input  logic [NUM_VOICES-1:0]           voice_idle,
  input  logic [NUM_VOICES-1:0]           voice_gate,
  input  logic [NUM_VOICES-1:0]           voice_active,
  input  logic [7*NUM_VOICES-1:0]         voice_note,
  input  logic [NUM_VOICES*RANK_BITS-1:0] ranks,
  output logic [RANK_BITS-1:0]            voice_sel,
  output logic                            steal
);

  logic                 hit_found, idle_found, rel_found;
  logic [RANK_BITS-1:0] hit_idx, idle_idx, rel_idx, old_idx;
  logic [RANK_BITS-1:0] rel_rank, old_rank, rank_i;

  always_comb begin
    hit_found  = 1'b0;
    idle_found = 1'b0;
    rel_found  = 1'b0;
    hit_idx    = '0;
    idle_idx   = '0;
    rel_idx    = '0;
    old_idx    = '0;
    rel_rank   = '0;
    old_rank   = '0;
    rank_i     = '0;
    // Ascending scan with strict compares keeps the lowest index on any tie.
    for (int i = 0; i < NUM_VOICES; i++) begin
      rank_i = ranks[i*RANK_BITS +: RANK_BITS];
      if (!hit_found && voice_active[i] && (voice_note[i*7 +: 7] == note)) begin
        hit_found = 1'b1;
        hit_idx   = RANK_BITS'(i);
      end
      if (!idle_found && voice_idle[i] && !voice_gate[i]) begin
        idle_found = 1'b1;
        idle_idx   = RANK_BITS'(i);
      end
      if (!voice_gate[i] && (!rel_found || (rank_i > rel_rank))) begin
        rel_found = 1'b1;
        rel_idx   = RANK_BITS'(i);
        rel_rank  = rank_i;
      end
      if ((i == 0) || (rank_i > old_rank)) begin
        old_idx  = RANK_BITS'(i);
        old_rank = rank_i;
      end
    end

    steal     = 1'b1;
    voice_sel = old_idx;
    if (hit_found) begin
      voice_sel = hit_idx;
    end else if (idle_found) begin
      voice_sel = idle_idx;
      steal     = 1'b0;
    end else if (rel_found) begin
      voice_sel = rel_idx;
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/off and all-notes-off onto per-voice gate/note/active.
// Idle voice gates 2 edges after accept; steals hold gate low RETRIG_CYCLES; ready only in IDLE.
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES    = 6,
  parameter int RETRIG_CYCLES = 400,
  parameter int RANK_BITS     = $clog2(NUM_VOICES)
) (
  input  logic                    clk,
  input  logic                    rst,
  midi_voice_allocator_if.slave   ev,
  input  logic [NUM_VOICES-1:0]   voice_idle,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic                    busy
);

  localparam int CNT_BITS = (RETRIG_CYCLES > 2) ? $clog2(RETRIG_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(RETRIG_CYCLES - 1);

  alloc_state_t                    state, state_nxt;
  logic [3:0]                      status_q;
  logic [6:0]                      p1_q, p2_q;
  logic [RANK_BITS-1:0]            rank_q [NUM_VOICES];
  logic [NUM_VOICES*RANK_BITS-1:0] rank_flat;
  logic [RANK_BITS-1:0]            pick_idx, tgt_q, tgt_rank;
  logic                            pick_steal;
  logic [CNT_BITS-1:0]             cnt_q;
  logic                            retrig_first_q;
  logic                            accept, is_note_on, is_note_off, is_all_off;
  logic                            chan_unused;

  // Omni: the channel nibble never affects allocation.
  assign chan_unused = ^ev.midi_command[3:0];

  assign accept      = ev.event_valid && (state == ST_IDLE);
  assign is_note_on  = (status_q == NOTE_ON) && (p2_q != 7'd0);
  assign is_note_off = (status_q == NOTE_OFF) || ((status_q == NOTE_ON) && (p2_q == 7'd0));
  assign is_all_off  = (status_q == CC) && (p1_q == ALL_NOTES_OFF);

  always_comb begin
    rank_flat = '0;
    tgt_rank  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      rank_flat[i*RANK_BITS +: RANK_BITS] = rank_q[i];
      if (tgt_q == RANK_BITS'(i)) tgt_rank = rank_q[i];
    end
  end

  voice_pick #(
    .NUM_VOICES (NUM_VOICES),
    .RANK_BITS  (RANK_BITS)
  ) u_voice_pick (
    .note         (p1_q),
    .voice_idle   (voice_idle),
    .voice_gate   (voice_gate),
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .ranks        (rank_flat),
    .voice_sel    (pick_idx),
    .steal        (pick_steal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    ev.event_ready = 1'b0;
    busy           = 1'b1;
    unique case (state)
      ST_IDLE: begin
        ev.event_ready = 1'b1;
        busy           = 1'b0;
        if (accept) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (!is_note_on)     state_nxt = ST_IDLE;
        else if (pick_steal) state_nxt = ST_RETRIG;
        else                 state_nxt = ST_ASSIGN;
      end
      ST_ASSIGN: state_nxt = ST_IDLE;
      ST_RETRIG: if (!retrig_first_q && (cnt_q == '0)) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q       <= '0;
      p1_q           <= '0;
      p2_q           <= '0;
      tgt_q          <= '0;
      cnt_q          <= '0;
      retrig_first_q <= 1'b0;
      voice_gate     <= '0;
      voice_active   <= '0;
      voice_note     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= RANK_BITS'(i);
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            status_q <= ev.midi_command[7:4];
            p1_q     <= ev.midi_param1;
            p2_q     <= ev.midi_param2;
          end
        end
        ST_SCAN: begin
          tgt_q          <= pick_idx;
          retrig_first_q <= is_note_on && pick_steal;
          if (is_all_off) begin
            voice_gate   <= '0;
            voice_active <= '0;
          end else if (is_note_off) begin
            // Note is kept so the release tail keeps its pitch.
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (voice_active[i] && (voice_note[i*7 +: 7] == p1_q)) begin
                voice_gate[i]   <= 1'b0;
                voice_active[i] <= 1'b0;
              end
            end
          end
        end
        ST_ASSIGN, ST_RETRIG: begin
          if ((state == ST_ASSIGN) || retrig_first_q) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (tgt_q == RANK_BITS'(i)) begin
                voice_note[i*7 +: 7] <= p1_q;
                voice_gate[i]        <= (state == ST_ASSIGN);
                voice_active[i]      <= 1'b1;
                rank_q[i]            <= '0;
              end else if (rank_q[i] < tgt_rank) begin
                rank_q[i] <= rank_q[i] + RANK_BITS'(1);
              end
            end
            if (state == ST_RETRIG) begin
              cnt_q          <= CNT_LOAD;
              retrig_first_q <= 1'b0;
            end
          end else if (cnt_q == '0) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (tgt_q == RANK_BITS'(i)) voice_gate[i] <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Randomized bench for midi_voice_allocator against an LRU-list reference model.
// Directed allocation/steal/note-off/all-off cases, random events, async reset mid-retrigger.
module tb_midi_voice_allocator;
  import midi_pkg::*;

  localparam int NV = 6;
  localparam int RC = 400;

  logic            clk = 1'b0;
  logic            rst;
  logic [NV-1:0]   idle_v;
  logic [NV-1:0]   voice_gate;
  logic [7*NV-1:0] voice_note;
  logic [NV-1:0]   voice_active;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Reference: lru[0] is the most recently assigned voice, lru[$] the oldest.
  bit       mgate [NV];
  bit       mact  [NV];
  bit [6:0] mnote [NV];
  int       lru[$];

  midi_voice_allocator_if ev();

  midi_voice_allocator #(
    .NUM_VOICES    (NV),
    .RETRIG_CYCLES (RC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ev           (ev.slave),
    .voice_idle   (idle_v),
    .voice_gate   (voice_gate),
    .voice_note   (voice_note),
    .voice_active (voice_active),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] eg, ea, en;
    eg = '0; ea = '0; en = '0;
    for (int i = 0; i < NV; i++) begin
      eg[i] = mgate[i];
      ea[i] = mact[i];
      en[i*7 +: 7] = mnote[i];
    end
    chk({tag, "_gate"},   64'(voice_gate),   eg);
    chk({tag, "_active"}, 64'(voice_active), ea);
    chk({tag, "_note"},   64'(voice_note),   en);
  endtask

  function automatic void model_reset();
    lru.delete();
    for (int i = 0; i < NV; i++) begin
      mgate[i] = 0; mact[i] = 0; mnote[i] = 0;
      lru.push_back(i);
    end
  endfunction

  function automatic void model_assign(input int v, input bit [6:0] n, input bit g);
    mnote[v] = n; mact[v] = 1; mgate[v] = g;
    for (int k = 0; k < lru.size(); k++) begin
      if (lru[k] == v) begin
        lru.delete(k);
        break;
      end
    end
    lru.push_front(v);
  endfunction

  function automatic void model_pick(input bit [6:0] n, output int v, output bit steal);
    v = -1;
    steal = 1;
    for (int i = 0; i < NV; i++)
      if (v < 0 && mact[i] && mnote[i] == n) v = i;
    if (v >= 0) return;
    for (int i = 0; i < NV; i++)
      if (v < 0 && idle_v[i] && !mgate[i]) begin v = i; steal = 0; end
    if (v >= 0) return;
    for (int k = lru.size() - 1; k >= 0; k--)
      if (v < 0 && !mgate[lru[k]]) v = lru[k];
    if (v < 0) v = lru[lru.size()-1];
  endfunction

  // Called at posedge+1; issues one event and checks every cycle boundary it defines.
  task automatic do_event(input logic [7:0] cmd, input logic [6:0] p1, input logic [6:0] p2);
    int v;
    bit steal, on, off, alloff;
    on     = (cmd[7:4] == 4'h9) && (p2 != 0);
    off    = (cmd[7:4] == 4'h8) || ((cmd[7:4] == 4'h9) && (p2 == 0));
    alloff = (cmd[7:4] == 4'hB) && (p1 == 7'd123);
    chk("ready_idle", 64'(ev.event_ready), 64'd1);
    ev.event_valid = 1'b1; ev.midi_command = cmd; ev.midi_param1 = p1; ev.midi_param2 = p2;
    @(posedge clk); #1;
    ev.event_valid = 1'b0;
    ev.midi_command = 8'($urandom); ev.midi_param1 = 7'($urandom); ev.midi_param2 = 7'($urandom);
    chk("busy_scan", 64'(busy), 64'd1);
    chk("ready_scan", 64'(ev.event_ready), 64'd0);
    if (!on) begin
      for (int i = 0; i < NV; i++) begin
        if (alloff || (off && mact[i] && mnote[i] == p1)) begin
          mgate[i] = 0; mact[i] = 0;
        end
      end
      @(posedge clk); #1;
      check_outputs("nonote");
      chk("ready_k1", 64'(ev.event_ready), 64'd1);
    end else begin
      model_pick(p1, v, steal);
      @(posedge clk); #1;
      chk("ready_k1_low", 64'(ev.event_ready), 64'd0);
      check_outputs("pick_hold");
      if (!steal) begin
        @(posedge clk); #1;
        model_assign(v, p1, 1);
        check_outputs("assign");
        chk("ready_assign", 64'(ev.event_ready), 64'd1);
      end else begin
        @(posedge clk); #1;
        model_assign(v, p1, 0);
        check_outputs("retrig_drop");
        chk("ready_retrig", 64'(ev.event_ready), 64'd0);
        repeat (RC - 1) @(posedge clk);
        #1;
        check_outputs("retrig_gap_end");
        @(posedge clk); #1;
        mgate[v] = 1;
        check_outputs("retrig_rise");
        chk("ready_retrig_done", 64'(ev.event_ready), 64'd1);
      end
    end
  endtask

  initial begin
    int v;
    bit steal;
    int r;
    logic [7:0] cmd;
    logic [6:0] p1, p2;
    rst = 1'b1;
    idle_v = '1;
    ev.event_valid = 1'b0; ev.midi_command = '0; ev.midi_param1 = '0; ev.midi_param2 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset_ready", 64'(ev.event_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < NV; n++) do_event(8'h90, 7'(60 + n), 7'd100);
    do_event(8'h90, 7'd70, 7'd100);
    do_event(8'h80, 7'd62, 7'd0);
    idle_v = '0;
    do_event(8'h90, 7'd80, 7'd100);
    do_event(8'h90, 7'd61, 7'd0);
    do_event(8'h90, 7'd61, 7'd100);
    do_event(8'h90, 7'd61, 7'd100);
    do_event(8'hB0, 7'd123, 7'd0);
    do_event(8'hB0, 7'd7, 7'd100);

    for (int t = 0; t < 40; t++) begin
      idle_v = NV'($urandom);
      r  = $urandom_range(0, 9);
      p1 = 7'(60 + $urandom_range(0, 7));
      p2 = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      cmd = {4'h9, 4'($urandom)};
      if (r == 5 || r == 6) cmd = {4'h8, 4'($urandom)};
      if (r == 7) begin
        cmd = {4'hB, 4'($urandom)};
        p1  = ($urandom_range(0, 1) == 0) ? 7'd123 : 7'($urandom);
      end
      if (r == 8) cmd = {($urandom_range(0, 1) == 0) ? 4'hE : 4'hC, 4'($urandom)};
      do_event(cmd, p1, p2);
    end

    do_event(8'hB3, 7'd123, 7'd0);
    idle_v = '0;
    model_pick(7'd90, v, steal);
    chk("reset_case_steal", 64'(steal), 64'd1);
    ev.event_valid = 1'b1; ev.midi_command = 8'h95; ev.midi_param1 = 7'd90; ev.midi_param2 = 7'd64;
    @(posedge clk); #1;
    ev.event_valid = 1'b0;
    repeat (201) @(posedge clk);
    #1;
    model_assign(v, 7'd90, 0);
    check_outputs("mid_retrig");
    chk("mid_retrig_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst_ready", 64'(ev.event_ready), 64'd1);
    chk("async_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    idle_v = '1;
    do_event(8'h90, 7'd50, 7'd90);
    chk("post_rst_voice0", 64'(voice_gate), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
